// File: rtl/jt51_mix_pkg.sv
// Shared definitions for the jt51_mix stereo mixer: FSM encoding, saturation
// limits, accumulator sizing and the peak-magnitude helper.
package jt51_mix_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    // Worst-case sum of CH products (signed 16 x unsigned GW) plus a sign bit.
    function automatic int acc_width(input int ch, input int gw);
        return 16 + gw + $clog2(ch) + 1;
    endfunction

    // |v| in 15 bits; the one value that does not fit (-32768) is clamped.
    function automatic logic [14:0] mag15(input logic signed [15:0] v);
        logic signed [15:0] n;
        if (v == 16'sh8000) return 15'h7fff;
        n = v[15] ? -v : v;
        return n[14:0];
    endfunction

endpackage

// File: rtl/jt51_mix_sat.sv
// Rescales one accumulator by the unity-gain shift and saturates it to a
// signed 16-bit sample, flagging when the limit was hit.
module jt51_mix_sat
    import jt51_mix_pkg::*;
#(
    parameter int AW = 26,
    parameter int GW = 8
) (
    input  logic signed [AW-1:0] acc,
    output logic signed [15:0]   dout,
    output logic                 clip
);

    localparam logic signed [AW-1:0] HI = AW'(SAT_MAX);
    localparam logic signed [AW-1:0] LO = AW'(SAT_MIN);

    logic signed [AW-1:0] shifted;

    assign shifted = acc >>> (GW - 2);

    always_comb begin
        dout = shifted[15:0];
        clip = 1'b0;
        if (shifted > HI) begin
            dout = 16'sh7fff;
            clip = 1'b1;
        end else if (shifted < LO) begin
            dout = 16'sh8000;
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/jt51_mix.sv
// Time-multiplexed CH-source stereo mixer with per-source gain, saturation
// and sticky status flags. Peak meters exist only with JT51_MIX_PEAK_EN.
module jt51_mix
    import jt51_mix_pkg::*;
#(
    parameter int CH = 2,
    parameter int GW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic                 sample_in,
    input  logic [CH*16-1:0]     din_l,
    input  logic [CH*16-1:0]     din_r,
    input  logic                 gain_we,
    input  logic [2:0]           gain_addr,
    input  logic [GW-1:0]        gain_din,
    output logic signed [15:0]   left,
    output logic signed [15:0]   right,
    output logic                 sample_out,
    output logic                 busy,
    output logic                 overrun,
    output logic                 clip,
    input  logic                 flag_clr,
    output logic [14:0]          peak_l,
    output logic [14:0]          peak_r,
    input  logic                 peak_clr
);

    localparam int AW = acc_width(CH, GW);
    localparam int PW = 17 + GW;
    localparam logic [GW-1:0] UNITY = GW'(2 ** (GW - 2));

    logic [1:0]           state;
    logic [2:0]           idx;
    logic [CH*16-1:0]     snap_l, snap_r;
    logic [GW-1:0]        gain_pend [CH];
    logic [GW-1:0]        gain_act  [CH];
    logic signed [AW-1:0] acc_l, acc_r;
    logic signed [15:0]   cur_l, cur_r, res_l, res_r;
    logic [GW-1:0]        cur_g;
    logic signed [PW-1:0] prod_l, prod_r;
    logic                 clip_l, clip_r;
    logic                 start, last;

    assign start = cen && (state == ST_IDLE) && sample_in;
    assign last  = (idx == 3'(CH - 1));

    always_comb begin
        cur_l = '0;
        cur_r = '0;
        cur_g = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (idx == 3'(k)) begin
                cur_l = snap_l[16*k +: 16];
                cur_r = snap_r[16*k +: 16];
                cur_g = gain_act[k];
            end
        end
    end

    // Gain is zero-extended so it always acts as a positive multiplier.
    assign prod_l = PW'(cur_l) * $signed(PW'({1'b0, cur_g}));
    assign prod_r = PW'(cur_r) * $signed(PW'({1'b0, cur_g}));

    // A write landing on the start clock bypasses straight into the active copy.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < CH; k++) begin
            if (rst) begin
                gain_pend[k] <= UNITY;
                gain_act[k]  <= UNITY;
            end else begin
                if (gain_we && gain_addr == 3'(k))
                    gain_pend[k] <= gain_din;
                if (start)
                    gain_act[k] <= (gain_we && gain_addr == 3'(k)) ? gain_din : gain_pend[k];
            end
        end
    end

    jt51_mix_sat #(.AW(AW), .GW(GW)) u_sat_l (
        .acc  (acc_l),
        .dout (res_l),
        .clip (clip_l)
    );

    jt51_mix_sat #(.AW(AW), .GW(GW)) u_sat_r (
        .acc  (acc_r),
        .dout (res_r),
        .clip (clip_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            busy       <= 1'b0;
            acc_l      <= '0;
            acc_r      <= '0;
            snap_l     <= '0;
            snap_r     <= '0;
            left       <= '0;
            right      <= '0;
            sample_out <= 1'b0;
            overrun    <= 1'b0;
            clip       <= 1'b0;
        end else begin
            sample_out <= 1'b0;
            overrun    <= (cen && sample_in && busy) || (overrun && !flag_clr);
            clip       <= (cen && state == ST_DONE && (clip_l || clip_r)) || (clip && !flag_clr);
            if (cen) begin
                case (state)
                    ST_IDLE: begin
                        if (sample_in) begin
                            snap_l <= din_l;
                            snap_r <= din_r;
                            acc_l  <= '0;
                            acc_r  <= '0;
                            idx    <= '0;
                            busy   <= 1'b1;
                            state  <= ST_ACC;
                        end
                    end
                    ST_ACC: begin
                        acc_l <= acc_l + AW'(prod_l);
                        acc_r <= acc_r + AW'(prod_r);
                        idx   <= idx + 3'd1;
                        if (last)
                            state <= ST_DONE;
                    end
                    ST_DONE: begin
                        left       <= res_l;
                        right      <= res_r;
                        sample_out <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef JT51_MIX_PEAK_EN
    logic [14:0] pk_l, pk_r, mag_l, mag_r;

    assign mag_l = mag15(res_l);
    assign mag_r = mag15(res_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            pk_l <= '0;
            pk_r <= '0;
        end else if (cen && state == ST_DONE) begin
            if (mag_l > pk_l) pk_l <= mag_l;
            if (mag_r > pk_r) pk_r <= mag_r;
        end else if (peak_clr) begin
            pk_l <= '0;
            pk_r <= '0;
        end
    end

    assign peak_l = pk_l;
    assign peak_r = pk_r;
`else
    logic unused_peak_clr;

    assign unused_peak_clr = peak_clr;
    assign peak_l = '0;
    assign peak_r = '0;
`endif

endmodule

// File: doc/jt51_mix.md
JT51_MIX -- requirements
Module: jt51_mix

Interface
REQ-001 Parameter CH, default 2: number of stereo sources mixed (1..8).
REQ-002 Parameter GW, default 8: gain word width; unity gain = 2^(GW-2).
REQ-003 Ports, in order:
- clk  in  1  main clock.
- rst  in  1  reset; synchronous, active-high.
- cen  in  1  clock enable; all state advances only when cen=1.
- sample_in  in  1  new-sample strobe from sources; sampled when cen=1.
- din_l  in  CH*16  signed left inputs; source k occupies bits [16k+15:16k].
- din_r  in  CH*16  signed right inputs; same packing.
- gain_we  in  1  gain register write strobe.
- gain_addr  in  3  source index for the write.
- gain_din  in  GW  unsigned gain value.
- left, right  out  16  signed mixed output.
- sample_out  out  1  one-clock pulse when left/right update.
- busy  out  1  high while a mix is in progress.
- overrun  out  1  sticky: sample_in arrived while busy.
- clip  out  1  sticky: an output saturated.
- flag_clr  in  1  clears overrun and clip.
- peak_l, peak_r  out  15  peak magnitude (see Configuration).
- peak_clr  in  1  clears peak registers.

Function
REQ-004 States: IDLE, ACC, DONE; the FSM moves only on cen=1 clocks.
REQ-005 IDLE with sample_in=1: snapshot din_l/din_r, copy pending gains into active gains, clear both accumulators, index:=0, go to ACC, busy:=1.
REQ-006 ACC: each cen, acc_x += snap_x[index] * gain[index] (signed 16 x unsigned GW, zero-extended gain); index increments; after index=CH-1 go to DONE.
REQ-007 Accumulator width = 16+GW+ceil(log2(CH))+1; no internal overflow for any input.
REQ-008 DONE: result = acc arithmetically shifted right by GW-2; saturate to [-32768, 32767]; load left/right; pulse sample_out for exactly one clk; clear busy; go to IDLE.
REQ-009 Latency sample_in to sample_out = CH+1 cen cycles; left/right hold between updates.
REQ-010 sample_in while busy: ignored, no state change, overrun:=1.
REQ-011 Saturation on either side sets clip:=1.
REQ-012 flag_clr clears overrun and clip; if a setting event occurs in the same clock, the set wins.
REQ-013 gain_we writes the pending gain of gain_addr on any clk (not cen-gated); gain_addr>=CH is ignored.
REQ-014 Pending gains reach the active set only at the REQ-005 transition; a write during ACC affects the next sample only.
REQ-015 A write in the same clock as the REQ-005 transition is included in that copy.

Reset
REQ-016 rst forces IDLE, busy=0, left=right=0, sample_out=0, overrun=clip=0, peaks=0, accumulators=0.
REQ-017 rst sets all pending and active gains to unity (2^(GW-2)).
REQ-018 rst mid-mix aborts it; no sample_out is produced for that sample.

Configuration
REQ-019 Macro JT51_MIX_PEAK_EN: when defined, each DONE updates peak_x = max(peak_x, |result_x|) with |-32768| clamped to 32767; peak_clr zeroes peaks, and an update in the same clk wins.
REQ-020 Without JT51_MIX_PEAK_EN: peak_l/peak_r tie to 0, peak_clr is ignored, and no peak registers exist.

Structure
REQ-021 Shared package jt51_mix_pkg holds the FSM state encoding, the saturation limits, and the accumulator width function.
REQ-022 One sub-module, jt51_mix_sat, performs the shift and saturation and flags clipping; it is instantiated once per side.

Verification
REQ-023 CH=2, unity gains, L0=1000, L1=-300 -> left=700 after 3 cen cycles; one sample_out pulse.
REQ-024 Gain0=0x80 (2x), L0=20000, L1=0 -> left=32767, clip=1; flag_clr -> clip=0.
REQ-025 Second sample_in one cen after the first -> overrun=1, only one sample_out, result unchanged.
REQ-026 Gain write of 0 to source 1 during ACC -> current sample unchanged; next sample excludes source 1.
REQ-027 rst asserted in ACC -> busy=0, no sample_out, gains read back as 0x40 (unity).
REQ-028 JT51_MIX_PEAK_EN, outputs -32768 then 100 -> peak=32767; peak_clr -> 0.
